// File: rtl/map_pkg.sv
// rtl/map_pkg.sv - shared defaults, cell values, FSM encoding and ring helper for map_ram
package map_pkg;

    localparam int MAP_COLBITS = 4;
    localparam int MAP_ROWBITS = 4;
    localparam int MAP_BITS    = 2;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_WALL_A = 2'd1;
    localparam logic [1:0] CELL_WALL_B = 2'd2;
    localparam logic [1:0] CELL_WALL_C = 2'd3;

    localparam logic [1:0] MAP_BORDER_VAL = CELL_WALL_C;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } map_state_e;

    // True when (row, col) lies on the outer ring of the grid.
    function automatic logic is_ring(int row, int col, int maxrow, int maxcol);
        return (row == 0) || (row == maxrow) || (col == 0) || (col == maxcol);
    endfunction

endpackage

// File: rtl/map_ram_if.sv
// rtl/map_ram_if.sv - read channel and write handshake bundle for map_ram
interface map_ram_if #(
    parameter int RD_CH   = 2,
    parameter int ROWBITS = 4,
    parameter int COLBITS = 4,
    parameter int BITS    = 2
);
    logic [RD_CH-1:0]         rd_en;
    logic [RD_CH*ROWBITS-1:0] rd_row;
    logic [RD_CH*COLBITS-1:0] rd_col;
    logic [RD_CH*BITS-1:0]    rd_val;
    logic [RD_CH-1:0]         rd_valid;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [ROWBITS-1:0]       wr_row;
    logic [COLBITS-1:0]       wr_col;
    logic [BITS-1:0]          wr_data;
    logic                     init_busy;

    modport master (
        output rd_en, rd_row, rd_col, wr_valid, wr_row, wr_col, wr_data,
        input  rd_val, rd_valid, wr_ready, init_busy
    );

    modport slave (
        input  rd_en, rd_row, rd_col, wr_valid, wr_row, wr_col, wr_data,
        output rd_val, rd_valid, wr_ready, init_busy
    );
endinterface

// File: rtl/map_init_seq.sv
// rtl/map_init_seq.sv - init sweep counter producing bordered-map write address/data and done
module map_init_seq
    import map_pkg::*;
#(
    parameter int              ROWBITS    = MAP_ROWBITS,
    parameter int              COLBITS    = MAP_COLBITS,
    parameter int              BITS       = MAP_BITS,
    parameter logic [BITS-1:0] BORDER_VAL = MAP_BORDER_VAL
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [ROWBITS-1:0] wr_row_o,
    output logic [COLBITS-1:0] wr_col_o,
    output logic [BITS-1:0]    wr_data_o,
    output logic               done_o
);
    localparam int ADDRBITS = ROWBITS + COLBITS;
    localparam int MAXROW   = (1 << ROWBITS) - 1;
    localparam int MAXCOL   = (1 << COLBITS) - 1;

    logic [ADDRBITS-1:0] cnt_q;
    logic [ADDRBITS-1:0] cnt_d;

    // Next sweep address; wraps naturally from all-ones back to zero.
    always_comb begin
        cnt_d = cnt_q + ADDRBITS'(1);
    end

    // Sweep counter advances one cell per enabled cycle, restarts on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    // Address is {row,col} = counter; ring cells get the border value.
    always_comb begin
        wr_row_o  = cnt_q[ADDRBITS-1 -: ROWBITS];
        wr_col_o  = cnt_q[COLBITS-1:0];
        wr_data_o = '0;
        if (is_ring(int'(wr_row_o), int'(wr_col_o), MAXROW, MAXCOL)) begin
            wr_data_o = BORDER_VAL;
        end
        done_o = en_i & (&cnt_q);
    end

endmodule

// File: rtl/map_ram.sv
// rtl/map_ram.sv - multi-read-port writable map RAM with self-init sweep (optional MAP_BORDER_FORCE_EN)
module map_ram
    import map_pkg::*;
#(
    parameter int              COLBITS    = MAP_COLBITS,
    parameter int              ROWBITS    = MAP_ROWBITS,
    parameter int              BITS       = MAP_BITS,
    parameter int              RD_CH      = 2,
    parameter logic [BITS-1:0] BORDER_VAL = MAP_BORDER_VAL
) (
    input  logic     clk,
    input  logic     reset,
    map_ram_if.slave bus
);
    localparam int ADDRBITS = ROWBITS + COLBITS;
    localparam int CELLS    = 1 << ADDRBITS;
`ifdef MAP_BORDER_FORCE_EN
    localparam int MAXROW   = (1 << ROWBITS) - 1;
    localparam int MAXCOL   = (1 << COLBITS) - 1;
`endif

    map_state_e state_q;
    map_state_e state_d;
    logic       init_busy;
    logic       wr_ready;
    logic       init_done;

    logic [ROWBITS-1:0] init_row;
    logic [COLBITS-1:0] init_col;
    logic [BITS-1:0]    init_data;

    logic                host_keep;
    logic                mem_we;
    logic [ADDRBITS-1:0] mem_waddr;
    logic [BITS-1:0]     mem_wdata;
    logic [BITS-1:0]     mem_q [CELLS];

    logic [RD_CH*BITS-1:0] rd_val_d;
    logic [RD_CH*BITS-1:0] rd_val_q;
    logic [RD_CH-1:0]      rd_valid_q;

    map_init_seq #(
        .ROWBITS   (ROWBITS),
        .COLBITS   (COLBITS),
        .BITS      (BITS),
        .BORDER_VAL(BORDER_VAL)
    ) u_init_seq (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (init_busy),
        .wr_row_o (init_row),
        .wr_col_o (init_col),
        .wr_data_o(init_data),
        .done_o   (init_done)
    );

    // FSM state register: reset always restarts the sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave INIT once the last cell is written; RUN is terminal.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_done) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs: host writes are only accepted in RUN.
    always_comb begin
        init_busy = 1'b1;
        wr_ready  = 1'b0;
        case (state_q)
            ST_RUN: begin
                init_busy = 1'b0;
                wr_ready  = 1'b1;
            end
            default: begin
                init_busy = 1'b1;
                wr_ready  = 1'b0;
            end
        endcase
    end

    // Write arbitration: the sweep owns the array in INIT, the host in RUN.
    always_comb begin
        host_keep = bus.wr_valid & wr_ready;
`ifdef MAP_BORDER_FORCE_EN
        if (is_ring(int'(bus.wr_row), int'(bus.wr_col), MAXROW, MAXCOL)) begin
            host_keep = 1'b0;
        end
`endif
        mem_we    = init_busy | host_keep;
        mem_waddr = init_busy ? {init_row, init_col} : {bus.wr_row, bus.wr_col};
        mem_wdata = init_busy ? init_data : bus.wr_data;
    end

    // Cell storage; contents come from the init sweep, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Per-channel read lookup: old contents (read-first), zero during INIT.
    always_comb begin
        logic [ROWBITS-1:0] r;
        logic [COLBITS-1:0] c;
        rd_val_d = '0;
        r        = '0;
        c        = '0;
        for (int i = 0; i < RD_CH; i++) begin
            r = bus.rd_row[i*ROWBITS +: ROWBITS];
            c = bus.rd_col[i*COLBITS +: COLBITS];
            if (!init_busy) begin
                rd_val_d[i*BITS +: BITS] = mem_q[{r, c}];
`ifdef MAP_BORDER_FORCE_EN
                if (is_ring(int'(r), int'(c), MAXROW, MAXCOL)) begin
                    rd_val_d[i*BITS +: BITS] = BORDER_VAL;
                end
`endif
            end
        end
    end

    // Read registers: valid follows rd_en by one cycle, data holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_val_q   <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            for (int i = 0; i < RD_CH; i++) begin
                if (bus.rd_en[i]) begin
                    rd_val_q[i*BITS +: BITS] <= rd_val_d[i*BITS +: BITS];
                end
            end
        end
    end

    assign bus.rd_val    = rd_val_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_ready  = wr_ready;
    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_map_ram.sv
// tb/tb_map_ram.sv - directed plus random bench for map_ram against a grid model
module tb_map_ram;
    import map_pkg::*;

    localparam int RD_CH = 2;
    localparam int RB    = 4;
    localparam int CB    = 4;
    localparam int BITS  = 2;
    localparam int N     = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    map_ram_if #(.RD_CH(RD_CH), .ROWBITS(RB), .COLBITS(CB), .BITS(BITS)) bus ();

    map_ram #(
        .COLBITS   (CB),
        .ROWBITS   (RB),
        .BITS      (BITS),
        .RD_CH     (RD_CH),
        .BORDER_VAL(CELL_WALL_C)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] grid [N][N];
    int         init_left;
    logic [1:0] exp_val   [RD_CH];
    logic       exp_valid [RD_CH];

    function automatic logic on_ring(int r, int c);
        return (r == 0) || (r == N - 1) || (c == 0) || (c == N - 1);
    endfunction

    function automatic logic [1:0] ref_read(int r, int c);
`ifdef MAP_BORDER_FORCE_EN
        if (on_ring(r, c)) return 2'd3;
`endif
        return grid[r][c];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                grid[r][c] = on_ring(r, c) ? 2'd3 : 2'd0;
        init_left = N * N;
        for (int ch = 0; ch < RD_CH; ch++) begin
            exp_valid[ch] = 1'b0;
            exp_val[ch]   = 2'd0;
        end
    endtask

    task automatic check_outputs();
        chk("init_busy", 32'(bus.init_busy), 32'(init_left > 0));
        chk("wr_ready", 32'(bus.wr_ready), 32'(init_left == 0));
        for (int ch = 0; ch < RD_CH; ch++) begin
            chk($sformatf("rd_valid%0d", ch), 32'(bus.rd_valid[ch]), 32'(exp_valid[ch]));
            chk($sformatf("rd_val%0d", ch), 32'(bus.rd_val[ch*BITS +: BITS]), 32'(exp_val[ch]));
        end
    endtask

    // One clock: predict from the current inputs, advance, compare.
    task automatic tick();
        logic pre_busy;
        pre_busy = (init_left > 0);
        for (int ch = 0; ch < RD_CH; ch++) begin
            if (bus.rd_en[ch]) begin
                exp_valid[ch] = 1'b1;
                exp_val[ch]   = pre_busy ? 2'd0 :
                    ref_read(int'(bus.rd_row[ch*RB +: RB]), int'(bus.rd_col[ch*CB +: CB]));
            end else begin
                exp_valid[ch] = 1'b0;
            end
        end
        if (bus.wr_valid && !pre_busy)
            grid[int'(bus.wr_row)][int'(bus.wr_col)] = bus.wr_data;
        if (init_left > 0) init_left--;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_rd(input int ch, input bit en, input int r, input int c);
        bus.rd_en[ch]            = en;
        bus.rd_row[ch*RB +: RB]  = RB'(r);
        bus.rd_col[ch*CB +: CB]  = CB'(c);
    endtask

    task automatic set_wr(input bit v, input int r, input int c, input int d);
        bus.wr_valid = v;
        bus.wr_row   = RB'(r);
        bus.wr_col   = CB'(c);
        bus.wr_data  = BITS'(d);
    endtask

    task automatic rand_reads();
        for (int ch = 0; ch < RD_CH; ch++)
            set_rd(ch, 1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, N - 1));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        reset_model();
        check_outputs();
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outputs();
    endtask

    initial begin
        bus.rd_en  = '0;
        bus.rd_row = '0;
        bus.rd_col = '0;
        set_wr(1, 2, 2, int'(CELL_WALL_A));
        do_reset(3);

        // Partial INIT with a pending host write, then reset mid-sweep.
        repeat (100) begin
            rand_reads();
            tick();
        end
        do_reset(2);

        // Full sweep from release: busy for N*N cycles, no write accepted.
        repeat (N * N) begin
            rand_reads();
            tick();
        end
        tick();
        set_wr(0, 0, 0, 0);
        set_rd(0, 0, 0, 0);
        set_rd(1, 0, 0, 0);
        tick();

        // Bordered empty map after init.
        set_rd(0, 1, 0, 0);
        set_rd(1, 1, 15, 7);
        tick();
        chk("corner_0_0", 32'(bus.rd_val[1:0]), 32'd3);
        chk("edge_15_7", 32'(bus.rd_val[3:2]), 32'd3);
        set_rd(0, 1, 0, 15);
        set_rd(1, 1, 5, 5);
        tick();
        chk("corner_0_15", 32'(bus.rd_val[1:0]), 32'd3);
        chk("interior_5_5", 32'(bus.rd_val[3:2]), 32'd0);
        set_rd(0, 0, 0, 0);
        set_rd(1, 0, 0, 0);

        // Write then read next cycle; valid is a single pulse, value holds.
        set_wr(1, 3, 4, int'(CELL_WALL_B));
        tick();
        set_wr(0, 0, 0, 0);
        set_rd(0, 1, 3, 4);
        tick();
        chk("wr_rd_3_4", 32'(bus.rd_val[1:0]), 32'd2);
        chk("valid_pulse", 32'(bus.rd_valid[0]), 32'd1);
        set_rd(0, 0, 0, 0);
        tick();
        chk("valid_drop", 32'(bus.rd_valid[0]), 32'd0);
        chk("val_hold", 32'(bus.rd_val[1:0]), 32'd2);

        // Same-cycle collision is read-first.
        set_wr(1, 6, 6, int'(CELL_WALL_A));
        set_rd(1, 1, 6, 6);
        tick();
        chk("collide_old", 32'(bus.rd_val[3:2]), 32'd0);
        set_wr(0, 0, 0, 0);
        tick();
        chk("collide_new", 32'(bus.rd_val[3:2]), 32'd1);
        set_rd(1, 0, 0, 0);

        // Two channels at once, then identical addresses.
        set_wr(1, 1, 1, 1);
        tick();
        set_wr(1, 14, 14, 2);
        tick();
        set_wr(0, 0, 0, 0);
        set_rd(0, 1, 1, 1);
        set_rd(1, 1, 14, 14);
        tick();
        chk("dual_read", 32'(bus.rd_val), 32'b1001);
        set_rd(0, 1, 14, 14);
        tick();
        chk("same_addr", 32'(bus.rd_val[1:0]), 32'(bus.rd_val[3:2]));
        chk("same_addr_val", 32'(bus.rd_val[1:0]), 32'd2);
        set_rd(0, 0, 0, 0);
        set_rd(1, 0, 0, 0);

        // Ring write: handshake completes; stored or discarded per build.
        set_wr(1, 0, 5, 0);
        #1;
        chk("ring_wr_ready", 32'(bus.wr_ready), 32'd1);
        tick();
        set_wr(0, 0, 0, 0);
        set_rd(0, 1, 0, 5);
        tick();
`ifdef MAP_BORDER_FORCE_EN
        chk("ring_force", 32'(bus.rd_val[1:0]), 32'd3);
`else
        chk("ring_plain", 32'(bus.rd_val[1:0]), 32'd0);
`endif

        // Random RUN traffic against the grid model.
        repeat (400) begin
            rand_reads();
            set_wr(1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
                   $urandom_range(0, N - 1), $urandom_range(0, 3));
            tick();
        end
        set_wr(0, 0, 0, 0);
        set_rd(0, 0, 0, 0);
        set_rd(1, 0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
